// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the control unit of the 16-bit CPU.
//   CPU_ADDR_W / CPU_DATA_W / CPU_OPC_W : default widths (word-addressed instruction space)
//   CPU_PC_RESET                        : fetch PC after reset
//   CPU_OPC_LSB                         : opcode field is instr[CPU_DATA_W-1 -: CPU_OPC_W]
//   fetch_state_e                       : fetch request tracker, encoded as {pending, drop}
package cpu_pkg;

    localparam int          CPU_ADDR_W   = 16;
    localparam int          CPU_DATA_W   = 16;
    localparam int          CPU_OPC_W    = 2;
    localparam logic [15:0] CPU_PC_RESET = 16'd10;
    localparam int          CPU_OPC_LSB  = CPU_DATA_W - CPU_OPC_W;

    // Bit 1 = a request is outstanding, bit 0 = its response must be thrown away.
    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_WAIT  = 2'b10,
        FS_STALE = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read handshake.
//   imem_req/imem_addr    : request, accepted when imem_req && imem_ready
//   imem_rvalid/imem_rdata: one response per accepted request, at least one cycle later
//   master = fetch stage, slave = instruction memory
interface instr_fetch_if import cpu_pkg::*; #(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: 2-entry {instr, pc} queue between instruction memory and decode.
//   push_i/instr_i/pc_i : write an entry
//   pop_i               : drop the head (ignored when empty)
//   flush_i             : empty the queue; wins over push and pop
//   instr_o/pc_o        : head entry, straight from registers
//   count_o             : occupancy 0..2
// Entry 0 is always the head, so outputs never pass through a read mux.
module fetch_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop, do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // Full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        count_d  = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_d = instr_i;
                        pc0_d    = pc_i;
                    end else begin
                        instr0_d = instr1_q;
                        pc0_d    = pc1_q;
                        instr1_d = instr_i;
                        pc1_d    = pc_i;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_d = instr_i;
                        pc0_d    = pc_i;
                    end else begin
                        instr1_d = instr_i;
                        pc1_d    = pc_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    instr0_d = instr1_q;
                    pc0_d    = pc1_q;
                    count_d  = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            count_q  <= 2'd0;
        end else begin
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            count_q  <= count_d;
        end
    end

    assign instr_o = instr0_q;
    assign pc_o    = pc0_q;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 16-bit CPU.
//   clk, reset                    : clock, synchronous active-high reset
//   imem (instr_fetch_if.master)  : word reads from instruction memory, one outstanding
//   redirect_valid/redirect_pc    : taken branch/jump; flushes all in-flight fetch work
//   stall                         : decode cannot accept this cycle
//   out_valid/out_instr/out_pc/out_opcode : head of the 2-entry fetch queue to decode
module instr_fetch import cpu_pkg::*; #(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter int                OPC_W    = CPU_OPC_W,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(CPU_PC_RESET)
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    input  logic                 stall,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_instr,
    output logic [ADDR_W-1:0]    out_pc,
    output logic [OPC_W-1:0]     out_opcode
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fetch_pc_q, pending_pc_q;
    logic [1:0]        count;
    logic              pending, drop, accept, rsp, push, pop;

    assign pending = (state_q != FS_IDLE);
    assign drop    = (state_q == FS_STALE);

    // Issuing only with a free slot guarantees the response always fits.
    assign imem.imem_req  = !reset && !pending && (count != 2'd2) && !redirect_valid;
    assign imem.imem_addr = fetch_pc_q;

    assign accept = imem.imem_req && imem.imem_ready;
    // A response with nothing outstanding is ignored.
    assign rsp    = imem.imem_rvalid && pending;
    assign push   = rsp && !drop && !redirect_valid;
    assign pop    = out_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            fetch_pc_q   <= PC_RESET;
            pending_pc_q <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            // A response still on its way belongs to the old path.
            state_q    <= (pending && !rsp) ? FS_STALE : FS_IDLE;
        end else if (accept) begin
            state_q      <= FS_WAIT;
            pending_pc_q <= fetch_pc_q;
            fetch_pc_q   <= fetch_pc_q + ADDR_W'(1);
        end else if (rsp) begin
            state_q <= FS_IDLE;
        end
    end

    fetch_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .instr_i (imem.imem_rdata),
        .pc_i    (pending_pc_q),
        .instr_o (out_instr),
        .pc_o    (out_pc),
        .count_o (count)
    );

    assign out_valid  = (count != 2'd0);
    assign out_opcode = out_instr[DATA_W-1 -: OPC_W];

`ifndef SYNTHESIS
    rvalid_needs_pending: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rvalid |-> pending);
`endif

endmodule
